// File: rtl/core_pkg.sv
// core_pkg: shared types, widths and helpers for the execute stage
// Provides the ALU and forwarding encodings, the branch funct3 codes,
// the ID/EX and EX/MEM pipeline register layouts and the forwarding mux.
package core_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_SLTU = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLL  = 3'b110,
    ALU_SRL  = 3'b111
  } alu_ctrl_t;
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef struct packed {
    logic [XLEN-1:0]       rd1;
    logic [XLEN-1:0]       rd2;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       pc_plus4;
    logic [REG_ADDR_W-1:0] rd;
    alu_ctrl_t             alu_control;
    logic [2:0]            funct3;
    logic                  alu_src;
    logic                  reg_write;
    logic                  mem_write;
    logic                  branch;
    logic                  jump;
    logic                  jalr;
    logic [1:0]            result_src;
  } id_ex_t;
  typedef struct packed {
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       write_data;
    logic [XLEN-1:0]       pc_plus4;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_write;
    logic [1:0]            result_src;
  } ex_mem_t;
  // The unused code 11 falls through to the register value.
  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel, input logic [XLEN-1:0] r,
                                              input logic [XLEN-1:0] wb, input logic [XLEN-1:0] mem);
    return sel == FWD_WB ? wb : sel == FWD_MEM ? mem : r;
  endfunction
endpackage

// File: rtl/execute_stage_alu.sv
// alu: combinational RV32I ALU for the 3-bit aluControl encoding
// Ports: a_i/b_i operands, ctrl_i operation, result_o wrapped result.
module alu import core_pkg::*; #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  alu_ctrl_t    ctrl_i,
  output logic [W-1:0] result_o
);
  always_comb begin
    case (ctrl_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_SLTU: result_o = W'(a_i < b_i);
      ALU_SLT:  result_o = W'($signed(a_i) < $signed(b_i));
      ALU_SLL:  result_o = a_i << b_i[4:0];
      ALU_SRL:  result_o = a_i >> b_i[4:0];
      default:  result_o = '0;
    endcase
  end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: RV32I EX stage with ID/EX register, forwarding, ALU, branch resolve and EX/MEM register
// Ports: *D decode-side inputs, forwardAE/BE + resultW forwarding, pcSrcE/pcTargetE
// combinational fetch redirect, *M registered EX/MEM outputs.
module execute_stage import core_pkg::*; #(
  parameter int XLEN = core_pkg::XLEN,
  parameter int REG_ADDR_W = core_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flushE,
  input  logic [XLEN-1:0]       rd1D,
  input  logic [XLEN-1:0]       rd2D,
  input  logic [XLEN-1:0]       immD,
  input  logic [XLEN-1:0]       pcD,
  input  logic [XLEN-1:0]       pcPlus4D,
  input  logic [REG_ADDR_W-1:0] rdD,
  input  logic [2:0]            aluControlD,
  input  logic [2:0]            funct3D,
  input  logic                  aluSrcD,
  input  logic                  regWriteD,
  input  logic                  memWriteD,
  input  logic                  branchD,
  input  logic                  jumpD,
  input  logic                  jalrD,
  input  logic [1:0]            resultSrcD,
  input  logic [1:0]            forwardAE,
  input  logic [1:0]            forwardBE,
  input  logic [XLEN-1:0]       resultW,
  output logic                  pcSrcE,
  output logic [XLEN-1:0]       pcTargetE,
  output logic [XLEN-1:0]       aluResultM,
  output logic [XLEN-1:0]       writeDataM,
  output logic [XLEN-1:0]       pcPlus4M,
  output logic [REG_ADDR_W-1:0] rdM,
  output logic                  regWriteM,
  output logic                  memWriteM,
  output logic [1:0]            resultSrcM
);
  id_ex_t ide_d, ide_q;
  ex_mem_t exm_d, exm_q;
  logic [XLEN-1:0] src_a, write_data, src_b, alu_result, jalr_sum;
  logic [2:0] f3;
  logic taken;
  // A flush loads an all-zero bubble, which also clears the data fields.
  always_comb ide_d = flushE ? id_ex_t'('0) : id_ex_t'{
    rd1: rd1D, rd2: rd2D, imm: immD, pc: pcD, pc_plus4: pcPlus4D, rd: rdD,
    alu_control: alu_ctrl_t'(aluControlD), funct3: funct3D, alu_src: aluSrcD,
    reg_write: regWriteD, mem_write: memWriteD, branch: branchD, jump: jumpD,
    jalr: jalrD, result_src: resultSrcD};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ide_q <= '0;
      exm_q <= '0;
    end else begin
      ide_q <= ide_d;
      exm_q <= exm_d;
    end
  end
  assign src_a      = fwd_mux(forwardAE, ide_q.rd1, resultW, exm_q.alu_result);
  assign write_data = fwd_mux(forwardBE, ide_q.rd2, resultW, exm_q.alu_result);
  assign src_b      = ide_q.alu_src ? ide_q.imm : write_data;
  alu #(.W(XLEN)) u_alu (
    .a_i      (src_a),
    .b_i      (src_b),
    .ctrl_i   (ide_q.alu_control),
    .result_o (alu_result)
  );
  // Branch compare works on the forwarded operands, not on the ALU result.
  assign f3 = ide_q.funct3;
  assign taken = f3 == F3_BEQ  ? src_a == write_data :
                 f3 == F3_BNE  ? src_a != write_data :
                 f3 == F3_BLT  ? $signed(src_a) <  $signed(write_data) :
                 f3 == F3_BGE  ? $signed(src_a) >= $signed(write_data) :
                 f3 == F3_BLTU ? src_a <  write_data :
                 f3 == F3_BGEU ? src_a >= write_data : 1'b0;
  assign jalr_sum  = src_a + ide_q.imm;
  assign pcSrcE    = (ide_q.branch & taken) | ide_q.jump;
  assign pcTargetE = ide_q.jalr ? {jalr_sum[XLEN-1:1], 1'b0} : ide_q.pc + ide_q.imm;
  always_comb exm_d = ex_mem_t'{
    alu_result: alu_result, write_data: write_data, pc_plus4: ide_q.pc_plus4,
    rd: ide_q.rd, reg_write: ide_q.reg_write, mem_write: ide_q.mem_write,
    result_src: ide_q.result_src};
  assign aluResultM = exm_q.alu_result;
  assign writeDataM = exm_q.write_data;
  assign pcPlus4M   = exm_q.pc_plus4;
  assign rdM        = exm_q.rd;
  assign regWriteM  = exm_q.reg_write;
  assign memWriteM  = exm_q.mem_write;
  assign resultSrcM = exm_q.result_src;
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- RV32I execute stage for the pipelined core; sits directly downstream of the ALU decoder.
- Owns the ID/EX pipeline register, the forwarding operand muxes and the ALU that implements the 3-bit aluControl encoding.
- Resolves branches and jumps for fetch, and drives the EX/MEM pipeline register.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flushE  in  1  insert bubble into ID/EX on next edge
rd1D  in  XLEN  decode register operand 1
rd2D  in  XLEN  decode register operand 2
immD  in  XLEN  sign-extended immediate
pcD  in  XLEN  instruction PC
pcPlus4D  in  XLEN  PC+4
rdD  in  REG_ADDR_W  destination register
aluControlD  in  3  ALU decoder output
funct3D  in  3  branch condition select
aluSrcD  in  1  1 = srcB is immediate
regWriteD, memWriteD, branchD, jumpD, jalrD  in  1 each  control flags
resultSrcD  in  2  writeback select, passed through
forwardAE, forwardBE  in  2  00 register, 01 resultW, 10 aluResultM
resultW  in  XLEN  writeback-stage result
pcSrcE  out  1  redirect fetch (combinational)
pcTargetE  out  XLEN  redirect address (combinational)
aluResultM, writeDataM, pcPlus4M  out  XLEN  EX/MEM register
rdM  out  REG_ADDR_W  EX/MEM register
regWriteM, memWriteM  out  1  EX/MEM register
resultSrcM  out  2  EX/MEM register

Behaviour:
- Reset: clk and rst_n only; reset is asynchronous and active-low. Every ID/EX and EX/MEM register clears to 0 while rst_n=0, so all M outputs read 0. pcSrcE is 0 during and directly after reset because branchE = jumpE = 0.
- ID/EX register:
  - Captures all D inputs on each rising edge.
  - flushE=1 at an edge loads a bubble: regWrite, memWrite, branch, jump and jalr are 0; rd is 0; data fields are don't-care (implementation clears them).
- Operand muxes:
  - srcA = forwardAE-selected rd1E / resultW / aluResultM.
  - writeData = the same mux applied to rd2E with forwardBE.
  - srcB = aluSrcE ? immE : writeData.
  - forward code 11 is illegal; it selects the register value.
- ALU encoding:
  - 000 add; 001 sub; 010 and; 011 or.
  - 100 sltu: unsigned less-than, result zero-extended to XLEN.
  - 101 slt: signed less-than, result zero-extended to XLEN.
  - 110 sll, shift amount srcB[4:0]; 111 srl (logical), shift amount srcB[4:0].
  - add/sub wrap modulo 2^XLEN; no overflow flag.
- Branch compare: uses the forwarded srcA and writeData, independent of the ALU output.
  - funct3E 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
  - 010 and 011 are never taken.
- Redirect:
  - pcSrcE = (branchE & taken) | jumpE.
  - pcTargetE = jalrE ? ((srcA + immE) & ~1) : (pcE + immE).
- EX/MEM register:
  - Captures aluResult, writeData, pcPlus4E, rdE, regWriteE, memWriteE and resultSrcE on every edge.
  - A bubble in EX propagates as regWriteM = memWriteM = 0.
- Latency: one cycle from D inputs to E state; one further cycle to the M outputs. pcSrcE/pcTargetE are valid in the same cycle the instruction is in EX.
- Boundaries:
  - A flushed instruction never asserts pcSrcE.
  - When flushE coincides with a taken branch in EX, the branch redirects in that cycle and the younger instruction is bubbled.
  - A reset pulse mid-stream clears both registers asynchronously; the first edge after release captures D inputs normally.
  - rdE = 0 still propagates regWrite; suppressing writes to x0 belongs to the register file.

Decomposition:
- Shared package core_pkg:
  - alu_ctrl_t enum (ALU_ADD=000, ALU_SUB, ALU_AND, ALU_OR, ALU_SLTU, ALU_SLT, ALU_SLL, ALU_SRL).
  - fwd_sel_t enum (FWD_REG, FWD_WB, FWD_MEM).
  - Branch funct3 constants.
  - id_ex_t and ex_mem_t packed structs.
- One sub-module: alu (combinational; srcA, srcB, aluControl -> result). Instantiated inside execute_stage.

Test Plan:
- Reset: hold rst_n=0 with random D inputs, release -> all M outputs 0 and pcSrcE=0; the first post-reset instruction reaches the M outputs two edges after it is presented.
- ALU sweep: srcA=0x80000000, srcB=1 via immediate -> expected results per code:
  - add 0x80000001, sub 0x7FFFFFFF, and 0, or 0x80000001;
  - sltu 0, slt 1, sll 0, srl 0x40000000.
- Forwarding: rd1D=5, aluResultM=9, resultW=7, add with immediate 1:
  - forwardAE=10 -> aluResultM 10;
  - forwardAE=01 -> 8;
  - forwardAE=00 -> 6.
- Branches: srcA=0xFFFFFFFF, srcB=1, branchD=1:
  - blt -> pcSrcE 1; bltu -> 0; beq -> 0; bne -> 1;
  - pcTargetE = pc 0x100 + imm 0x20 = 0x120.
- JALR: srcA=0x203, imm=2, jalrD=jumpD=1 -> pcSrcE=1, pcTargetE=0x204, pcPlus4M carried to MEM.
- Flush: taken beq in EX with flushE=1 -> redirect that cycle; the next cycle has pcSrcE=0, and one edge later regWriteM=0, memWriteM=0.
